// File: rtl/pipelined_addsub_if.sv
// Handshake and operand/result bundle for pipelined_addsub.
// master = producer/consumer side, slave = the adder pipeline.
interface pipelined_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carryout, overflow, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Chunked carry-pipelined add/subtract with valid/ready flow control.
// Define ADDSUB_SATURATE_EN to clamp the presented sum on signed overflow.
module pipelined_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipelined_addsub_if.slave  bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Stage registers: valid, chunk carry, operands carried forward, partial sum.
    logic [STAGES-1:0] sv;
    logic [STAGES-1:0] sc;
    logic [WIDTH-1:0]  sa [STAGES];
    logic [WIDTH-1:0]  sb [STAGES];
    logic [WIDTH-1:0]  ss [STAGES];

    // Per-stage sources (stage 0 from the bus, stage k from stage k-1).
    logic [STAGES-1:0] pv;
    logic [STAGES-1:0] pc;
    logic [WIDTH-1:0]  pa [STAGES];
    logic [WIDTH-1:0]  pb [STAGES];
    logic [WIDTH-1:0]  ps [STAGES];

    logic [STAGES-1:0] nc;
    logic [WIDTH-1:0]  ns [STAGES];
    logic [CHUNK:0]    part;

    logic adv;

    assign adv          = !sv[LAST] || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        pv    = '0;
        pc    = '0;
        pv[0] = bus.in_valid;
        pc[0] = bus.sub;
        pa[0] = bus.a;
        pb[0] = bus.b ^ {WIDTH{bus.sub}};
        ps[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            pv[k] = sv[k-1];
            pc[k] = sc[k-1];
            pa[k] = sa[k-1];
            pb[k] = sb[k-1];
            ps[k] = ss[k-1];
        end
    end

    always_comb begin
        nc   = '0;
        part = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            part  = {1'b0, pa[k][k*CHUNK +: CHUNK]}
                  + {1'b0, pb[k][k*CHUNK +: CHUNK]}
                  + (CHUNK+1)'(pc[k]);
            ns[k] = ps[k];
            ns[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            nc[k] = part[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sv <= '0;
            sc <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sa[k] <= '0;
                sb[k] <= '0;
                ss[k] <= '0;
            end
        end else if (adv) begin
            sv <= pv;
            sc <= nc;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sa[k] <= pa[k];
                sb[k] <= pb[k];
                ss[k] <= ns[k];
            end
        end
    end

    logic             ovf;
    logic [WIDTH-1:0] result;

    assign ovf = (sa[LAST][WIDTH-1] == sb[LAST][WIDTH-1])
              && (ss[LAST][WIDTH-1] != sa[LAST][WIDTH-1]);

`ifdef ADDSUB_SATURATE_EN
    always_comb begin
        result = ss[LAST];
        if (ovf)
            result = sa[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign result = ss[LAST];
`endif

    assign bus.out_valid = sv[LAST];
    assign bus.sum       = result;
    assign bus.carryout  = sc[LAST];
    assign bus.overflow  = ovf;
    // Qualified by valid so an idle/reset pipeline never reports zero.
    assign bus.zero      = sv[LAST] && (result == '0);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=8, CHUNK=4) with a
// queue-based arithmetic reference model.
module tb_pipelined_addsub;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         z;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q[$];

    pipelined_addsub_if #(.WIDTH(W)) bus();

    pipelined_addsub #(.WIDTH(W), .CHUNK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic s);
        res_t e;
        int   r, ua, ub;
        r  = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        e.o   = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
        e.c   = s ? (ua >= ub) : (ua + ub > 2**W - 1);
        e.sum = W'(r);
`ifdef ADDSUB_SATURATE_EN
        if (e.o) e.sum = a[W-1] ? W'(8'h80) : W'(8'h7F);
`endif
        e.z = (e.sum == 0);
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: settle, score the handshake at this edge, advance, verify stalls.
    task automatic tick(output logic acc);
        res_t e, snap;
        logic stall;
        #1;
        acc = bus.in_valid && bus.in_ready && !reset;
        if (!reset) begin
            check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_result", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("sum", bus.sum, e.sum);
                    check("carryout", bus.carryout, e.c);
                    check("overflow", bus.overflow, e.o);
                    check("zero", bus.zero, e.z);
                end
            end
        end
        stall = bus.out_valid && !bus.out_ready && !reset;
        snap  = '{bus.sum, bus.carryout, bus.overflow, bus.zero};
        if (acc) q.push_back(model(bus.a, bus.b, bus.sub));
        @(posedge clk);
        #1;
        if (stall) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_fields", {bus.sum, bus.carryout, bus.overflow, bus.zero}, snap);
        end
    endtask

    task automatic run_single(logic [W-1:0] a, logic [W-1:0] b, logic s,
                              logic [W-1:0] es, logic ec, logic eo, logic ez);
        logic acc;
        int   lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = s;
        tick(acc);
        check("single_accept", acc, 1);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick(acc);
            lat++;
        end
        check("latency", lat, 2);
        check("d_sum", bus.sum, es);
        check("d_carry", bus.carryout, ec);
        check("d_ovf", bus.overflow, eo);
        check("d_zero", bus.zero, ez);
        tick(acc);
    endtask

    initial begin
        logic acc;
        int   n, cyc;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_carry", bus.carryout, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_zero", bus.zero, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        run_single(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        run_single(8'h70, 8'h20, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_single(8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
`else
        run_single(8'h70, 8'h20, 1'b0, 8'h90, 1'b0, 1'b1, 1'b0);
        run_single(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
`endif
        run_single(8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

        // Back-to-back random ops with out_ready toggling every cycle.
        n   = 0;
        cyc = 0;
        bus.in_valid = 1'b1;
        bus.a   = 8'($urandom);
        bus.b   = 8'($urandom);
        bus.sub = 1'($urandom);
        while (n < 16 && cyc < 200) begin
            bus.out_ready = cyc[0];
            tick(acc);
            cyc++;
            if (acc) begin
                n++;
                bus.a   = 8'($urandom);
                bus.b   = 8'($urandom);
                bus.sub = 1'($urandom);
            end
        end
        check("accept_count", n, 16);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            tick(acc);
            cyc++;
        end
        check("drain_pending", q.size(), 0);

        // Reset with two operations in flight; in_valid held high through reset.
        bus.in_valid = 1'b1;
        bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0;
        tick(acc);
        bus.a = 8'h33; bus.b = 8'h01; bus.sub = 1'b1;
        tick(acc);
        reset = 1'b1;
        tick(acc);
        check("rst_no_accept", acc, 0);
        q.delete();
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_carry", bus.carryout, 0);
        check("mid_rst_ovf", bus.overflow, 0);
        check("mid_rst_zero", bus.zero, 0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        repeat (6) begin
            tick(acc);
            check("no_stale", bus.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
